// File: rtl/cail_param_arbiter.sv
// Round-robin arbiter sharing the single calibration parameter store port
// between the host (read/write) and the measurement engine (read only).
module cail_param_arbiter #(
    parameter int CH_W   = 4,
    parameter int TYPE_W = 2,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [CH_W-1:0]   a_ch,
    input  logic [TYPE_W-1:0] a_type,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic [CH_W-1:0]   b_ch,
    input  logic [TYPE_W-1:0] b_type,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              wr_req,
    output logic              rd_req,
    output logic [CH_W-1:0]   ch,
    output logic [TYPE_W-1:0] ptype,
    output logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] result,
    output logic              busy,
    output logic              grant_b
);

    localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                we_q;
    logic                last_b_q;
    logic                grant_b_q;
    logic                busy_q;
    logic                wr_req_q;
    logic                rd_req_q;
    logic                a_ack_q;
    logic                b_ack_q;
    logic [CH_W-1:0]     ch_q;
    logic [TYPE_W-1:0]   type_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   a_rdata_q;
    logic [DATA_W-1:0]   b_rdata_q;
    logic                grant_b_d;

    // On a tie, serve whichever requester was not served last.
    assign grant_b_d = b_req && (!a_req || !last_b_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            last_b_q  <= 1'b1;
            grant_b_q <= 1'b0;
            busy_q    <= 1'b0;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            ch_q      <= '0;
            type_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (a_req || b_req) begin
                        grant_b_q <= grant_b_d;
                        we_q      <= !grant_b_d && a_we;
                        ch_q      <= grant_b_d ? b_ch : a_ch;
                        type_q    <= grant_b_d ? b_type : a_type;
                        if (!grant_b_d)
                            wdata_q <= a_wdata;
                        wr_req_q  <= !grant_b_d && a_we;
                        rd_req_q  <= grant_b_d || !a_we;
                        busy_q    <= 1'b1;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (we_q) begin
                        a_ack_q <= !grant_b_q;
                        b_ack_q <= grant_b_q;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= CNT_W'(RD_LAT);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        if (grant_b_q)
                            b_rdata_q <= result;
                        else
                            a_rdata_q <= result;
                        a_ack_q <= !grant_b_q;
                        b_ack_q <= grant_b_q;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    last_b_q <= grant_b_q;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wr_req  = wr_req_q;
    assign rd_req  = rd_req_q;
    assign ch      = ch_q;
    assign ptype   = type_q;
    assign in_data = wdata_q;
    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign busy    = busy_q;
    assign grant_b = grant_b_q;

endmodule

// File: tb/tb_cail_param_arbiter.sv
// Bench for cail_param_arbiter: directed vector table, corner-case sequences,
// and randomized two-requester traffic against a transaction-level model.
module tb_cail_param_arbiter;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [3:0]  a_ch = '0;
    logic [1:0]  a_type = '0;
    logic [31:0] a_wdata = '0;
    logic        a_ack;
    logic [31:0] a_rdata;
    logic        b_req = 1'b0;
    logic [3:0]  b_ch = '0;
    logic [1:0]  b_type = '0;
    logic        b_ack;
    logic [31:0] b_rdata;
    logic        wr_req, rd_req;
    logic [3:0]  ch;
    logic [1:0]  ptype;
    logic [31:0] in_data;
    logic [31:0] result = '0;
    logic        busy, grant_b;

    // second instance with a one-cycle store latency
    logic        b2_req = 1'b0;
    logic [3:0]  b2_ch = '0;
    logic [1:0]  b2_type = '0;
    logic        a2_req = 1'b0, a2_we = 1'b0;
    logic [3:0]  a2_ch = '0;
    logic [1:0]  a2_type = '0;
    logic [31:0] a2_wdata = '0;
    logic        a2_ack, b2_ack, wr_req2, rd_req2, busy2, grant_b2;
    logic [31:0] a2_rdata, b2_rdata, in_data2;
    logic [31:0] result2 = '0;
    logic [3:0]  ch2;
    logic [1:0]  ptype2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cail_param_arbiter #(.CH_W(4), .TYPE_W(2), .DATA_W(32), .RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_ch(a_ch), .a_type(a_type), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_ch(b_ch), .b_type(b_type), .b_ack(b_ack), .b_rdata(b_rdata),
        .wr_req(wr_req), .rd_req(rd_req), .ch(ch), .ptype(ptype), .in_data(in_data),
        .result(result), .busy(busy), .grant_b(grant_b)
    );

    cail_param_arbiter #(.CH_W(4), .TYPE_W(2), .DATA_W(32), .RD_LAT(1)) u_dut_rl1 (
        .clk(clk), .rst(rst),
        .a_req(a2_req), .a_we(a2_we), .a_ch(a2_ch), .a_type(a2_type), .a_wdata(a2_wdata),
        .a_ack(a2_ack), .a_rdata(a2_rdata),
        .b_req(b2_req), .b_ch(b2_ch), .b_type(b2_type), .b_ack(b2_ack), .b_rdata(b2_rdata),
        .wr_req(wr_req2), .rd_req(rd_req2), .ch(ch2), .ptype(ptype2), .in_data(in_data2),
        .result(result2), .busy(busy2), .grant_b(grant_b2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Store model: memory written by wr_req, read data presented RD_LAT cycles
    // after the rd_req cycle, random junk otherwise.
    logic [31:0] smem [16][4];
    int          rd_due = -10;
    logic [31:0] rd_val = '0;

    // Transaction-level reference for the randomized phase.
    logic        model_on = 1'b0;
    logic [31:0] mmem [16][4];
    int          m_free = 0;
    int          m_ack_cyc = -1;
    logic        m_last_b = 1'b1;
    logic        m_owner_b = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_data = '0;

    always @(negedge clk) begin
        chk("strobe_excl", {31'b0, wr_req & rd_req}, 32'd0);
        chk("strobe_busy", {31'b0, (wr_req | rd_req) & !busy}, 32'd0);
        result = (cyc == rd_due) ? rd_val : $urandom;
        if (wr_req) smem[ch][ptype] = in_data;
        if (rd_req) begin
            rd_due = cyc + RD_LAT;
            rd_val = smem[ch][ptype];
        end
        if (model_on) begin
            if (cyc == m_ack_cyc) begin
                chk("rnd_a_ack", {31'b0, a_ack}, {31'b0, !m_owner_b});
                chk("rnd_b_ack", {31'b0, b_ack}, {31'b0, m_owner_b});
                if (!m_we) chk("rnd_rdata", m_owner_b ? b_rdata : a_rdata, m_data);
            end else begin
                chk("rnd_no_ack", {31'b0, a_ack | b_ack}, 32'd0);
            end
            if (cyc >= m_free && (a_req || b_req)) begin
                m_owner_b = b_req && (!a_req || !m_last_b);
                m_last_b  = m_owner_b;
                m_we      = !m_owner_b && a_we;
                m_ack_cyc = cyc + (m_we ? 2 : 2 + RD_LAT);
                m_free    = m_ack_cyc + 1;
                if (m_we) mmem[a_ch][a_type] = a_wdata;
                else if (m_owner_b) m_data = mmem[b_ch][b_type];
                else m_data = mmem[a_ch][a_type];
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One transaction from a single requester; reports ack latency and rdata.
    task automatic do_txn(input logic is_b, input logic we, input logic [3:0] c,
                          input logic [1:0] ty, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd);
        logic wr;
        wr = we && !is_b;
        @(posedge clk); #1;
        if (is_b) begin
            b_req = 1'b1; b_ch = c; b_type = ty;
        end else begin
            a_req = 1'b1; a_we = we; a_ch = c; a_type = ty; a_wdata = wd;
        end
        lat = -1;
        rd  = '0;
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            @(posedge clk); #1;
            chk("txn_busy", {31'b0, busy}, 32'd1);
            if (k == 1) begin
                chk("issue_wr", {31'b0, wr_req}, {31'b0, wr});
                chk("issue_rd", {31'b0, rd_req}, {31'b0, !wr});
                chk("issue_ch", {28'b0, ch}, {28'b0, c});
                chk("issue_type", {30'b0, ptype}, {30'b0, ty});
                chk("issue_grant", {31'b0, grant_b}, {31'b0, is_b});
                if (wr) chk("issue_data", in_data, wd);
            end else begin
                chk("strobe_off", {31'b0, wr_req | rd_req}, 32'd0);
            end
            if (a_ack || b_ack) begin
                lat = k;
                rd  = is_b ? b_rdata : a_rdata;
                chk("ack_owner", {31'b0, b_ack}, {31'b0, is_b});
                a_req = 1'b0;
                b_req = 1'b0;
            end
        end
    endtask

    // Both requesters raise a read together; returns their ack cycles.
    task automatic run_pair(output int ta, output int tb_);
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b0; a_ch = 4'd1; a_type = 2'd0;
        b_req = 1'b1; b_ch = 4'd2; b_type = 2'd0;
        ta = -1; tb_ = -1;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            if (a_ack) begin ta = k; a_req = 1'b0; chk("pair_a_rdata", a_rdata, 32'hA1A1A1A1); end
            if (b_ack) begin tb_ = k; b_req = 1'b0; chk("pair_b_rdata", b_rdata, 32'hB2B2B2B2); end
        end
    endtask

    typedef struct {
        logic        is_b;
        logic        we;
        logic [3:0]  c;
        logic [1:0]  ty;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int          lat, ta, tb_, t, bcnt, b1t, b2t;
        logic [31:0] rd;

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 4; j++) smem[i][j] = '0;

        // write rows expect the requester's rdata to stay at its previous read value
        vecs[0] = '{1'b0, 1'b1, 4'd3,  2'd1, 32'h11223344, 2, 32'h00000000};
        vecs[1] = '{1'b0, 1'b0, 4'd3,  2'd1, 32'h0,        4, 32'h11223344};
        vecs[2] = '{1'b0, 1'b1, 4'd1,  2'd0, 32'hA1A1A1A1, 2, 32'h11223344};
        vecs[3] = '{1'b0, 1'b1, 4'd2,  2'd0, 32'hB2B2B2B2, 2, 32'h11223344};
        vecs[4] = '{1'b1, 1'b0, 4'd3,  2'd1, 32'h0,        4, 32'h11223344};
        vecs[5] = '{1'b1, 1'b0, 4'd15, 2'd3, 32'h0,        4, 32'h00000000};
        vecs[6] = '{1'b0, 1'b1, 4'd15, 2'd3, 32'hCAFEF00D, 2, 32'h11223344};
        vecs[7] = '{1'b1, 1'b1, 4'd15, 2'd3, 32'h0,        4, 32'hCAFEF00D};
        vecs[8] = '{1'b0, 1'b0, 4'd2,  2'd0, 32'h0,        4, 32'hB2B2B2B2};
        vecs[9] = '{1'b0, 1'b1, 4'd0,  2'd0, 32'h5A5A5A5A, 2, 32'hB2B2B2B2};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_ack", {31'b0, a_ack}, 32'd0);
        chk("rst_b_ack", {31'b0, b_ack}, 32'd0);
        chk("rst_strobes", {30'b0, wr_req, rd_req}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_grant_b", {31'b0, grant_b}, 32'd0);
        chk("rst_bus", {26'b0, ch, ptype}, 32'd0);
        chk("rst_in_data", in_data, 32'd0);
        chk("rst_rdata", a_rdata | b_rdata, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_txn(vecs[i].is_b, vecs[i].we, vecs[i].c, vecs[i].ty, vecs[i].wd, lat, rd);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
        end

        // req dropped after one cycle still completes
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b0; a_ch = 4'd15; a_type = 2'd3;
        t = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 1) a_req = 1'b0;
            if (a_ack && t < 0) begin t = k; chk("drop_rdata", a_rdata, 32'hCAFEF00D); end
        end
        chk("drop_lat", t, 4);

        // simultaneous requests after reset: A first, then B; later B first
        do_reset();
        run_pair(ta, tb_);
        chk("pair1_a", ta, 4);
        chk("pair1_b", tb_, 9);
        do_txn(1'b0, 1'b1, 4'd0, 2'd0, 32'h0F0F0F0F, lat, rd);
        chk("lone_a_lat", lat, 2);
        run_pair(ta, tb_);
        chk("pair2_b", tb_, 4);
        chk("pair2_a", ta, 9);

        // B requesting continuously must not starve a pending A write
        @(posedge clk); #1;
        b_req = 1'b1; b_ch = 4'd2; b_type = 2'd0;
        t = -1; bcnt = 0; b1t = -1; b2t = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin a_req = 1'b1; a_we = 1'b1; a_ch = 4'd5; a_type = 2'd2; a_wdata = 32'h55AA55AA; end
            if (a_ack) begin t = k; a_req = 1'b0; end
            if (b_ack) begin
                bcnt++;
                if (bcnt == 1) b1t = k;
                if (bcnt == 2) b2t = k;
                b_req = 1'b0;
            end else if (!b_req && bcnt < 3) begin
                b_req = 1'b1;
            end
        end
        chk("fair_b1", b1t, 4);
        chk("fair_a", t, 7);
        chk("fair_b2", b2t, 12);

        // reset during a B read WAIT abandons it; the held request is re-served
        @(posedge clk); #1;
        b_req = 1'b1; b_ch = 4'd2; b_type = 2'd0;
        repeat (2) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("midrst_strobes", {30'b0, wr_req, rd_req}, 32'd0);
        chk("midrst_acks", {30'b0, a_ack, b_ack}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_grant", {31'b0, grant_b}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_hold_ack", {31'b0, b_ack}, 32'd0);
        @(posedge clk); #3 rst = 1'b0;
        t = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (b_ack && t < 0) begin t = k; b_req = 1'b0; chk("midrst_rdata", b_rdata, 32'hB2B2B2B2); end
        end
        chk("midrst_lat", t, 4);

        // RD_LAT=1 instance
        @(posedge clk); #1;
        b2_req = 1'b1; b2_ch = 4'd15; b2_type = 2'd3;
        t = -1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            result2 = (k == 2) ? 32'hDEADBEEF : 32'h0BADF00D;
            if (k == 1) begin
                chk("rl1_rd_req", {31'b0, rd_req2}, 32'd1);
                chk("rl1_bus", {26'b0, ch2, ptype2}, {26'b0, 4'd15, 2'd3});
            end
            if (b2_ack && t < 0) begin t = k; b2_req = 1'b0; chk("rl1_rdata", b2_rdata, 32'hDEADBEEF); end
        end
        chk("rl1_lat", t, 3);

        // randomized traffic from both requesters
        do_reset();
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 4; j++) mmem[i][j] = smem[i][j];
        m_free = 0; m_ack_cyc = -1; m_last_b = 1'b1;
        model_on = 1'b1;
        fork
            begin
                int na;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
                    a_req = 1'b1; a_we = 1'($urandom_range(0, 1));
                    a_ch = 4'($urandom); a_type = 2'($urandom); a_wdata = $urandom;
                    na = 0;
                    while (!a_ack && na < 40) begin @(posedge clk); #1; na++; end
                    chk("rnd_a_done", {31'b0, a_ack}, 32'd1);
                    a_req = 1'b0;
                end
            end
            begin
                int nb;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
                    b_req = 1'b1; b_ch = 4'($urandom); b_type = 2'($urandom);
                    nb = 0;
                    while (!b_ack && nb < 40) begin @(posedge clk); #1; nb++; end
                    chk("rnd_b_done", {31'b0, b_ack}, 32'd1);
                    b_req = 1'b0;
                end
            end
        join
        repeat (4) @(posedge clk);
        model_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
